frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/frame_serializer_pkg.sv | 14 +
 rtl/frame_serializer_buf.sv | 29 ++
 rtl/frame_serializer.sv | 96 +++++++++
 tb/tb_frame_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared types and sizing for the frame serializer and its character buffer.
package frame_serializer_pkg;

    localparam int FB_DEPTH = 16;
    localparam int FB_AW    = 4;
    localparam int CHAR_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/frame_serializer_buf.sv
// 16x8 character buffer: synchronous write, combinational read, async clear.
// Read has zero latency; a same-edge write is seen only by the following cycle.
module frame_buf
    import frame_serializer_pkg::*;
(
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [FB_AW-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [FB_AW-1:0]  rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem_q [FB_DEPTH];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/frame_serializer.sv
// Serializes buffer entry addr[3:0] MSB-first whenever the address changes; one LOAD cycle then 8 bit cycles.
// No backpressure: enable only gates new bytes; a started byte always runs to completion.
module frame_serializer
    import frame_serializer_pkg::*;
(
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [FB_AW-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [FB_AW:0]    addr,
    input  logic              enable,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_sync,
    output logic              busy
);

    state_t            state_q;
    logic [FB_AW-1:0]  cur_addr_q;
    logic [FB_AW-1:0]  last_addr_q;
    logic [CHAR_W-1:0] shreg_q;
    logic [2:0]        bit_cnt_q;
    logic              sent_q;
    logic              ser_valid_q;
    logic              frame_sync_q;
    logic              busy_q;
    logic [CHAR_W-1:0] rd_data;
    logic              trigger;
    logic              addr_unused;

    assign addr_unused = addr[FB_AW];
    assign trigger     = enable && (!sent_q || (addr[FB_AW-1:0] != last_addr_q));

    frame_buf u_buf (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (cur_addr_q),
        .rd_data (rd_data)
    );

    // shreg drains to zero after 8 shifts, so its MSB is a clean 0 outside SHIFT.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            last_addr_q  <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            sent_q       <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q    <= LOAD;
                        cur_addr_q <= addr[FB_AW-1:0];
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg_q      <= rd_data;
                    bit_cnt_q    <= 3'd7;
                    frame_sync_q <= (cur_addr_q == '0);
                    ser_valid_q  <= 1'b1;
                    state_q      <= SHIFT;
                end
                SHIFT: begin
                    frame_sync_q <= 1'b0;
                    shreg_q      <= {shreg_q[CHAR_W-2:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_q     <= IDLE;
                        ser_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        last_addr_q <= cur_addr_q;
                        sent_q      <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ser_out    = shreg_q[CHAR_W-1];
    assign ser_valid  = ser_valid_q;
    assign frame_sync = frame_sync_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: directed scenarios plus random traffic against a timeline reference model.
module tb_frame_serializer;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] addr;
    logic       enable;
    logic       ser_out, ser_valid, frame_sync, busy;

    frame_serializer dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr       (addr),
        .enable     (enable),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_sync (frame_sync),
        .busy       (busy)
    );

    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a byte is a timeline counted in edges since its trigger edge.
    logic [7:0] m_mem [16];
    bit         m_active, m_sent;
    int         m_since;
    logic [3:0] m_cur, m_last;
    logic [7:0] m_byte;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_active = 0; m_sent = 0; m_since = 0;
        m_cur = 0; m_last = 0; m_byte = 0;
    endtask

    task automatic model_edge();
        bit trig;
        trig = enable && (!m_active || m_since >= 9) && (!m_sent || addr[3:0] != m_last);
        if (trig) begin
            m_active = 1; m_since = 0; m_cur = addr[3:0];
        end else if (m_active && m_since < 20) begin
            m_since++;
            if (m_since == 1) m_byte = m_mem[m_cur];
            if (m_since == 9) begin m_sent = 1; m_last = m_cur; end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    // Directed-test observation counters.
    logic [7:0] rx_byte;
    int rx_cnt, rx_ones, busy_cnt, sync_cnt;

    task automatic clr();
        rx_byte = 0; rx_cnt = 0; rx_ones = 0; busy_cnt = 0; sync_cnt = 0;
    endtask

    task automatic cycle();
        logic e_busy, e_valid, e_out, e_sync;
        @(posedge sysclk);
        if (!rst_n) model_reset(); else model_edge();
        #1;
        e_busy  = m_active && m_since <= 8;
        e_valid = m_active && m_since >= 1 && m_since <= 8;
        e_out   = e_valid ? m_byte[8 - m_since] : 1'b0;
        e_sync  = m_active && m_since == 1 && m_cur == 4'd0;
        chk("busy", busy, e_busy);
        chk("ser_valid", ser_valid, e_valid);
        chk("ser_out", ser_out, e_out);
        chk("frame_sync", frame_sync, e_sync);
        if (ser_valid) begin
            rx_byte = {rx_byte[6:0], ser_out};
            rx_cnt++;
            if (ser_out) rx_ones++;
        end
        if (busy) busy_cnt++;
        if (frame_sync) sync_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 0;
    endtask

    initial begin
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; addr = 0; enable = 0;
        model_reset();
        clr();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", ser_valid, 0);
        chk("rst_out", ser_out, 0);
        chk("rst_sync", frame_sync, 0);
        run(2);
        @(negedge sysclk) rst_n = 1;

        wr(4'd3, 8'hA5); wr(4'd0, 8'h81); wr(4'd4, 8'h0F);
        wr(4'd6, 8'h96); wr(4'd7, 8'h3C);

        // A5 on address 3, then a long hold that must not retrigger.
        addr = 5'd3; enable = 1; clr();
        run(12);
        chk("a5_byte", rx_byte, 8'hA5);
        chk("a5_bits", rx_cnt, 8);
        chk("a5_busy_cycles", busy_cnt, 9);
        clr();
        run(40);
        chk("hold_no_retrigger", rx_cnt, 0);

        addr = 5'd4; clr();
        run(12);
        chk("0f_byte", rx_byte, 8'h0F);

        addr = 5'd0; clr();
        run(12);
        chk("81_byte", rx_byte, 8'h81);
        chk("81_sync_pulses", sync_cnt, 1);

        // Address change at the third bit must not disturb the byte in flight.
        addr = 5'd6; clr();
        run(4);
        addr = 5'd7;
        run(20);
        chk("chg_bits", rx_cnt, 16);
        chk("chg_second_byte", rx_byte, 8'h3C);
        chk("chg_busy_cycles", busy_cnt, 18);

        // Write entry 5 on the same edge LOAD reads it.
        addr = 5'd5; clr();
        cycle();
        wr(4'd5, 8'hFF);
        run(10);
        chk("rw_old_byte", rx_byte, 8'h00);
        chk("rw_old_bits", rx_cnt, 8);
        addr = 5'd1;
        run(12);
        addr = 5'd5; clr();
        run(12);
        chk("rw_new_byte", rx_byte, 8'hFF);

        // Reset in the middle of a byte.
        addr = 5'd3; clr();
        run(5);
        rst_n = 0;
        #1;
        chk("midrst_valid", ser_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out", ser_out, 0);
        run(2);
        @(negedge sysclk) rst_n = 1;
        clr();
        cycle();
        chk("postrst_trigger", busy, 1);
        run(9);
        for (int a = 4; a < 20; a++) begin
            addr = 5'(a % 16);
            run(10);
        end
        chk("sweep_bits", rx_cnt, 136);
        chk("sweep_all_zero", rx_ones, 0);

        // Random traffic, including addr[4] noise and short address holds.
        for (int i = 0; i < 2000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 8'($urandom_range(0, 255));
            enable  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) addr = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
